algo_nr2u_req_sched: RTL
========================

Name: algo_nr2u_req_sched

Overview:
- Round-robin request scheduler in front of the nr2u 1r1w multi-read-port memory core.
- Merges NUMCLNT client request streams onto the core's NUMRUPT per-cycle ports and blocks same-cycle address hazards.
- Tags each issued read and routes returning ru_vld/ru_dout to the originating client, with a sticky protocol-error flag.

Parameters:
- NUMCLNT, 4, number of requesting clients
- BITCLNT, 2, client index width
- NUMRUPT, 2, core ports issued per cycle
- WIDTH, 32, data width
- BITADDR, 13, address width
- RD_LAT, 3, cycles from registered ru_read to ru_vld
- BITECNT, 16, error counter width (optional feature only)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- ready  in  1  core ready; no issue while 0
- cl_req  in  NUMCLNT  client request valid, held until granted
- cl_wr  in  NUMCLNT  1=write, 0=read
- cl_addr  in  NUMCLNT*BITADDR  request address
- cl_din  in  NUMCLNT*WIDTH  write data
- cl_gnt  out  NUMCLNT  request accepted this cycle (combinational)
- cl_rvld  out  NUMCLNT  read data valid
- cl_rdout  out  NUMCLNT*WIDTH  read data
- cl_rserr  out  NUMCLNT  corrected error on the returned read
- cl_rderr  out  NUMCLNT  uncorrectable error on the returned read
- ru_read  out  NUMRUPT  core read strobe
- ru_write  out  NUMRUPT  core write strobe
- ru_addr  out  NUMRUPT*BITADDR  core address per port
- ru_din  out  NUMRUPT*WIDTH  core write data per port
- ru_vld  in  NUMRUPT  core read valid
- ru_dout  in  NUMRUPT*WIDTH  core read data
- ru_serr  in  NUMRUPT  core corrected error
- ru_derr  in  NUMRUPT  core uncorrectable error
- proto_err  out  1  sticky: ru_vld without a matching tag, or a tag with no ru_vld

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; rr_ptr=0; tag pipeline cleared; proto_err=0.
- Grant: when ready=1, scan clients circularly from rr_ptr and grant the first NUMRUPT eligible requesters. Eligible means cl_req=1 and no address conflict.
  - Address conflict: same address as a client already granted this cycle, where either request is a write. The later client in scan order is deferred.
  - Read-read to the same address is allowed.
- ready=0: cl_gnt=0; rr_ptr and pending requests are held.
- Issue:
  - Granted requests are registered onto ports 0..k-1 in scan order next cycle, so issue latency is 1 cycle.
  - Unused ports drive read=write=0, addr=0, din=0.
- rr_ptr update: one past the last granted index, modulo NUMCLNT; unchanged if nothing is granted.
- Tag pipeline:
  - Per port, RD_LAT stages of {valid, client}, loaded when ru_read issues.
  - At stage RD_LAT, ru_vld[p] routes ru_dout/serr/derr to client tag[p] via cl_rvld/cl_rdout/cl_rserr/cl_rderr.
  - Response path is combinational, so response latency = 1 + RD_LAT cycles after cl_gnt.
  - If both ports return to the same client in one cycle, that is a protocol error: proto_err=1 and port 0 wins.
  - Any mismatch between tag valid and ru_vld sets proto_err, which stays set until reset.
- Writes produce no response.
- Reset asserted mid-operation discards in-flight tags; no responses are produced after reset.

Optional Feature:
- ALGO_NR2U_SCHED_ERRCNT_EN defined: adds outputs serr_cnt and derr_cnt (BITECNT bits each).
  - Each counts the ru_serr / ru_derr bits accompanying ru_vld, summed across ports, and saturates at all-ones.
  - Reset value 0.
- Not defined: the ports and counters are absent; no other behavioural change.

Decomposition:
- Shared package algo_nr2u_sched_pkg holds:
  - tag struct {vld, client}
  - function next_rr(ptr, last)
  - localparam for the saturating counter maximum
- One sub-module, algo_nr2u_rr_pick: combinational scan from rr_ptr with hazard masking, returning up to NUMRUPT grant indices and valids.

Test Plan:
- Requests from clients 0,1,2,3 as reads to addrs 10,11,12,13, ready=1 → cycle 0 grants 0,1 and cycle 1 grants 2,3; ports carry 10/11 then 12/13; cl_rvld[0] arrives 4 cycles after its grant.
- Client 1 writes and client 2 reads addr 0x40 in the same cycle, rr_ptr=0 → only client 1 granted; client 2 granted the next cycle; rr_ptr ends at 3.
- Clients 0 and 3 both read 0x40 → both granted in one cycle on ports 0 and 1.
- ready=0 for 5 cycles with all cl_req=1 → no cl_gnt, no ru_read, rr_ptr stable; grants resume on the first ready=1 cycle.
- Inject ru_vld[1]=1 with no tag at stage RD_LAT → proto_err=1 and stays 1 until rst pulses low.
- With ALGO_NR2U_SCHED_ERRCNT_EN, ru_serr on both ports for 3 returns → serr_cnt=6; force BITECNT all-ones → counter holds.

Source files
------------

// File: rtl/algo_nr2u_sched_pkg.sv
// algo_nr2u_sched_pkg: shared constants, tag type and round-robin helper for the nr2u request scheduler
package algo_nr2u_sched_pkg;
  localparam int NUMCLNT = 4;
  localparam int BITCLNT = 2;
  localparam int NUMRUPT = 2;
  localparam int WIDTH   = 32;
  localparam int BITADDR = 13;
  localparam int RD_LAT  = 3;
  localparam int BITECNT = 16;
  localparam int BITRCNT = $clog2(NUMRUPT + 1);
  localparam logic [BITECNT-1:0] ECNT_MAX = '1;

  typedef struct packed {
    logic               vld;
    logic [BITCLNT-1:0] client;
  } tag_t;

  // last is the scan offset of the final grant relative to ptr
  function automatic logic [BITCLNT-1:0] next_rr(input logic [BITCLNT-1:0] ptr, input logic [BITCLNT-1:0] last);
    int n;
    n = (int'(ptr) + int'(last) + 1) % NUMCLNT;
    return BITCLNT'(n);
  endfunction
endpackage

// File: rtl/algo_nr2u_rr_pick.sv
// algo_nr2u_rr_pick: circular scan from rr_ptr granting up to NUMRUPT requesters free of address hazards
module algo_nr2u_rr_pick import algo_nr2u_sched_pkg::*; (
  input  logic                       ready_i,
  input  logic [BITCLNT-1:0]         rr_ptr_i,
  input  logic [NUMCLNT-1:0]         req_i,
  input  logic [NUMCLNT-1:0]         wr_i,
  input  logic [NUMCLNT*BITADDR-1:0] addr_i,
  output logic [NUMCLNT-1:0]         gnt_o,
  output logic [NUMRUPT*BITCLNT-1:0] pick_idx_o,
  output logic [NUMRUPT-1:0]         pick_vld_o,
  output logic [BITCLNT-1:0]         last_off_o
);
  logic [BITCLNT-1:0] c;
  logic               hit;
  int                 n;

  always_comb begin
    gnt_o      = '0;
    pick_idx_o = '0;
    pick_vld_o = '0;
    last_off_o = '0;
    c          = '0;
    hit        = 1'b0;
    n          = 0;
    for (int i = 0; i < NUMCLNT; i++) begin
      c   = BITCLNT'((int'(rr_ptr_i) + i) % NUMCLNT);
      hit = 1'b0;
      // a write on either side of a same-address pair defers the later client
      for (int j = 0; j < NUMCLNT; j++)
        hit = hit | (gnt_o[j] & (addr_i[j*BITADDR +: BITADDR] == addr_i[c*BITADDR +: BITADDR]) & (wr_i[j] | wr_i[c]));
      if (ready_i && req_i[c] && !hit && n < NUMRUPT) begin
        gnt_o[c]                          = 1'b1;
        pick_idx_o[n*BITCLNT +: BITCLNT]  = c;
        pick_vld_o[n]                     = 1'b1;
        last_off_o                        = BITCLNT'(i);
        n++;
      end
    end
  end
endmodule

// File: rtl/algo_nr2u_req_sched.sv
// algo_nr2u_req_sched: round-robin client scheduler onto nr2u core ports with read tagging and response routing
// Optional saturating serr/derr counters under ALGO_NR2U_SCHED_ERRCNT_EN.
module algo_nr2u_req_sched import algo_nr2u_sched_pkg::*; (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ready,
  input  logic [NUMCLNT-1:0]         cl_req,
  input  logic [NUMCLNT-1:0]         cl_wr,
  input  logic [NUMCLNT*BITADDR-1:0] cl_addr,
  input  logic [NUMCLNT*WIDTH-1:0]   cl_din,
  output logic [NUMCLNT-1:0]         cl_gnt,
  output logic [NUMCLNT-1:0]         cl_rvld,
  output logic [NUMCLNT*WIDTH-1:0]   cl_rdout,
  output logic [NUMCLNT-1:0]         cl_rserr,
  output logic [NUMCLNT-1:0]         cl_rderr,
  output logic [NUMRUPT-1:0]         ru_read,
  output logic [NUMRUPT-1:0]         ru_write,
  output logic [NUMRUPT*BITADDR-1:0] ru_addr,
  output logic [NUMRUPT*WIDTH-1:0]   ru_din,
  input  logic [NUMRUPT-1:0]         ru_vld,
  input  logic [NUMRUPT*WIDTH-1:0]   ru_dout,
  input  logic [NUMRUPT-1:0]         ru_serr,
  input  logic [NUMRUPT-1:0]         ru_derr,
  output logic                       proto_err
`ifdef ALGO_NR2U_SCHED_ERRCNT_EN
  ,
  output logic [BITECNT-1:0]         serr_cnt,
  output logic [BITECNT-1:0]         derr_cnt
`endif
);
  logic [NUMRUPT*BITCLNT-1:0] pick_idx, clnt_q, clnt_d;
  logic [NUMRUPT-1:0]         pick_vld, rd_q, rd_d, wr_q, wr_d;
  logic [NUMRUPT*BITADDR-1:0] addr_q, addr_d;
  logic [NUMRUPT*WIDTH-1:0]   din_q, din_d;
  logic [BITCLNT-1:0]         last_off, rr_ptr_q, rr_ptr_d, c;
  logic                       proto_err_q, proto_err_d, mism, clash;
  tag_t                       tag_q [NUMRUPT][RD_LAT];
  tag_t                       t;

  algo_nr2u_rr_pick u_pick (
    .ready_i    (ready),
    .rr_ptr_i   (rr_ptr_q),
    .req_i      (cl_req),
    .wr_i       (cl_wr),
    .addr_i     (cl_addr),
    .gnt_o      (cl_gnt),
    .pick_idx_o (pick_idx),
    .pick_vld_o (pick_vld),
    .last_off_o (last_off)
  );

  always_comb begin
    rd_d   = '0;
    wr_d   = '0;
    addr_d = '0;
    din_d  = '0;
    clnt_d = '0;
    c      = '0;
    for (int p = 0; p < NUMRUPT; p++) begin
      c = pick_idx[p*BITCLNT +: BITCLNT];
      if (pick_vld[p]) begin
        rd_d[p]                      = ~cl_wr[c];
        wr_d[p]                      = cl_wr[c];
        addr_d[p*BITADDR +: BITADDR] = cl_addr[c*BITADDR +: BITADDR];
        din_d[p*WIDTH +: WIDTH]      = cl_wr[c] ? cl_din[c*WIDTH +: WIDTH] : '0;
        clnt_d[p*BITCLNT +: BITCLNT] = c;
      end
    end
    rr_ptr_d = |pick_vld ? next_rr(rr_ptr_q, last_off) : rr_ptr_q;
  end

  // walk ports high to low so port 0 overwrites on a same-client collision
  always_comb begin
    cl_rvld  = '0;
    cl_rdout = '0;
    cl_rserr = '0;
    cl_rderr = '0;
    mism     = 1'b0;
    clash    = 1'b0;
    t        = '0;
    for (int p = NUMRUPT - 1; p >= 0; p--) begin
      t    = tag_q[p][RD_LAT-1];
      mism = mism | (t.vld ^ ru_vld[p]);
      if (t.vld && ru_vld[p]) begin
        clash                             = clash | cl_rvld[t.client];
        cl_rvld[t.client]                 = 1'b1;
        cl_rdout[t.client*WIDTH +: WIDTH] = ru_dout[p*WIDTH +: WIDTH];
        cl_rserr[t.client]                = ru_serr[p];
        cl_rderr[t.client]                = ru_derr[p];
      end
    end
    proto_err_d = proto_err_q | mism | clash;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q        <= '0;
      wr_q        <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      clnt_q      <= '0;
      rr_ptr_q    <= '0;
      proto_err_q <= 1'b0;
      for (int p = 0; p < NUMRUPT; p++)
        for (int k = 0; k < RD_LAT; k++)
          tag_q[p][k] <= '0;
    end else begin
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      clnt_q      <= clnt_d;
      rr_ptr_q    <= rr_ptr_d;
      proto_err_q <= proto_err_d;
      for (int p = 0; p < NUMRUPT; p++) begin
        tag_q[p][0] <= {rd_q[p], clnt_q[p*BITCLNT +: BITCLNT]};
        for (int k = 1; k < RD_LAT; k++)
          tag_q[p][k] <= tag_q[p][k-1];
      end
    end
  end

  assign ru_read   = rd_q;
  assign ru_write  = wr_q;
  assign ru_addr   = addr_q;
  assign ru_din    = din_q;
  assign proto_err = proto_err_q;

`ifdef ALGO_NR2U_SCHED_ERRCNT_EN
  logic [BITECNT-1:0] serr_cnt_q, serr_cnt_d, derr_cnt_q, derr_cnt_d;
  logic [BITRCNT-1:0] sinc, dinc;
  logic [BITECNT+1:0] ssum, dsum;

  always_comb begin
    sinc = '0;
    dinc = '0;
    for (int p = 0; p < NUMRUPT; p++) begin
      sinc = sinc + BITRCNT'(ru_vld[p] & ru_serr[p]);
      dinc = dinc + BITRCNT'(ru_vld[p] & ru_derr[p]);
    end
    ssum       = {2'b00, serr_cnt_q} + (BITECNT+2)'(sinc);
    dsum       = {2'b00, derr_cnt_q} + (BITECNT+2)'(dinc);
    serr_cnt_d = |ssum[BITECNT+1:BITECNT] ? ECNT_MAX : ssum[BITECNT-1:0];
    derr_cnt_d = |dsum[BITECNT+1:BITECNT] ? ECNT_MAX : dsum[BITECNT-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      serr_cnt_q <= '0;
      derr_cnt_q <= '0;
    end else begin
      serr_cnt_q <= serr_cnt_d;
      derr_cnt_q <= derr_cnt_d;
    end
  end

  assign serr_cnt = serr_cnt_q;
  assign derr_cnt = derr_cnt_q;
`endif
endmodule
